// File: rtl/yon_bulucu_pkg.sv
// Shared widths, FSM state encoding and hop-rule constant for yon_bulucu.
package yon_bulucu_pkg;

    localparam int NODE_W = 4;
    localparam int DIR_W  = 2;
    localparam int HOPS_W = 2;

    // Offset in next(n,d) = (4*n[1:0] + HOP_K + d) mod 16
    localparam logic [NODE_W-1:0] HOP_K = 4'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH1 = 2'd1,
        SEARCH2 = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/yon_bulucu_sonraki_dugum.sv
// Combinational hop rule: node reached from dugum_i when leaving in direction yon_i.
module sonraki_dugum
    import yon_bulucu_pkg::*;
(
    input  logic [NODE_W-1:0] dugum_i,
    input  logic [DIR_W-1:0]  yon_i,
    output logic [NODE_W-1:0] sonraki_o
);

    // Only the low two node bits select the group; the sum wraps at 16.
    assign sonraki_o = {dugum_i[1:0], 2'b00} + HOP_K + {2'b00, yon_i};

endmodule

// File: rtl/yon_bulucu.sv
// Route finder: searches 1-hop then (optionally) 2-hop routes from source to
// destination, testing one candidate direction per cycle.
// Optional 2-hop search enabled by defining YON_BULUCU_IKI_ATLAMA_EN.
module yon_bulucu
    import yon_bulucu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] kaynak_dugumu,
    input  logic [NODE_W-1:0] hedef_dugumu,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIR_W-1:0]  yon,
    output logic [DIR_W-1:0]  ikinci_yon,
    output logic [HOPS_W-1:0] atlama_sayisi,
    output logic              bulundu
);

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [NODE_W-1:0]   src_q, src_d;
    logic [NODE_W-1:0]   dst_q, dst_d;
    logic [DIR_W-1:0]    yon_q, yon_d;
    logic [HOPS_W-1:0]   hops_q, hops_d;
    logic                found_q, found_d;
    logic [DIR_W-1:0]    d1;
    logic [NODE_W-1:0]   hop1;

`ifdef YON_BULUCU_IKI_ATLAMA_EN
    logic [DIR_W-1:0]    yon2_q, yon2_d;
    logic [NODE_W-1:0]   hop2;

    // In SEARCH2 the first hop direction comes from the upper index bits.
    assign d1 = (state_q == SEARCH2) ? idx_q[3:2] : idx_q[1:0];
`else
    assign d1 = idx_q[1:0];
`endif

    sonraki_dugum u_hop1 (
        .dugum_i   (src_q),
        .yon_i     (d1),
        .sonraki_o (hop1)
    );

`ifdef YON_BULUCU_IKI_ATLAMA_EN
    sonraki_dugum u_hop2 (
        .dugum_i   (hop1),
        .yon_i     (idx_q[1:0]),
        .sonraki_o (hop2)
    );
`endif

    // Next-state and result computation; one candidate is examined per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        dst_d   = dst_q;
        yon_d   = yon_q;
        hops_d  = hops_q;
        found_d = found_q;
`ifdef YON_BULUCU_IKI_ATLAMA_EN
        yon2_d  = yon2_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = kaynak_dugumu;
                    dst_d   = hedef_dugumu;
                    idx_d   = '0;
                    yon_d   = '0;
                    hops_d  = '0;
                    found_d = 1'b0;
`ifdef YON_BULUCU_IKI_ATLAMA_EN
                    yon2_d  = '0;
`endif
                    if (kaynak_dugumu == hedef_dugumu) begin
                        state_d = DONE;
                        found_d = 1'b1;
                    end else begin
                        state_d = SEARCH1;
                    end
                end
            end
            SEARCH1: begin
                if (hop1 == dst_q) begin
                    state_d = DONE;
                    yon_d   = idx_q[1:0];
                    hops_d  = 2'd1;
                    found_d = 1'b1;
                end else if (idx_q == 4'd3) begin
`ifdef YON_BULUCU_IKI_ATLAMA_EN
                    state_d = SEARCH2;
                    idx_d   = '0;
`else
                    // No 2-hop search: report "not found" with zeroed fields.
                    state_d = DONE;
`endif
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
`ifdef YON_BULUCU_IKI_ATLAMA_EN
            SEARCH2: begin
                if (hop2 == dst_q) begin
                    state_d = DONE;
                    yon_d   = idx_q[3:2];
                    yon2_d  = idx_q[1:0];
                    hops_d  = 2'd2;
                    found_d = 1'b1;
                end else if (idx_q == 4'd15) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
`endif
            DONE: begin
                idx_d = '0;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            yon_q   <= '0;
            hops_q  <= '0;
            found_q <= 1'b0;
`ifdef YON_BULUCU_IKI_ATLAMA_EN
            yon2_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            yon_q   <= yon_d;
            hops_q  <= hops_d;
            found_q <= found_d;
`ifdef YON_BULUCU_IKI_ATLAMA_EN
            yon2_q  <= yon2_d;
`endif
        end
    end

    // Captured request nodes; only meaningful after an accept.
    always_ff @(posedge clk) begin
        src_q <= src_d;
        dst_q <= dst_d;
    end

    assign in_ready      = (state_q == IDLE) && !rst;
    assign out_valid     = (state_q == DONE);
    assign yon           = yon_q;
    assign atlama_sayisi = hops_q;
    assign bulundu       = found_q;
`ifdef YON_BULUCU_IKI_ATLAMA_EN
    assign ikinci_yon    = yon2_q;
`else
    assign ikinci_yon    = '0;
`endif

endmodule

// File: tb/tb_yon_bulucu.sv
// Directed bench for yon_bulucu; expectations follow YON_BULUCU_IKI_ATLAMA_EN.
module tb_yon_bulucu;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] kaynak_dugumu;
    logic [3:0] hedef_dugumu;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] yon;
    logic [1:0] ikinci_yon;
    logic [1:0] atlama_sayisi;
    logic       bulundu;

    int n_checks = 0;
    int n_errors = 0;

    yon_bulucu dut (
        .clk           (clk),
        .rst           (rst),
        .kaynak_dugumu (kaynak_dugumu),
        .hedef_dugumu  (hedef_dugumu),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .yon           (yon),
        .ikinci_yon    (ikinci_yon),
        .atlama_sayisi (atlama_sayisi),
        .bulundu       (bulundu)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency from accept, check result, hold
    // out_ready low for 'hold' cycles, then complete the handshake.
    task automatic do_req(input logic [3:0] s, input logic [3:0] d, input int lat,
                          input logic [1:0] y, input logic [1:0] y2,
                          input logic [1:0] h, input logic f, input int hold);
        int c;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        kaynak_dugumu = s;
        hedef_dugumu  = d;
        in_valid      = 1'b1;
        @(negedge clk);
        // Garbage while busy must be ignored.
        kaynak_dugumu = ~s;
        hedef_dugumu  = ~d;
        c = 1;
        while (!out_valid && c < 40) begin
            chk("busy_in_ready", in_ready, 0);
            @(negedge clk);
            c++;
        end
        chk("latency", c, lat);
        chk("yon", yon, y);
        chk("ikinci_yon", ikinci_yon, y2);
        chk("atlama_sayisi", atlama_sayisi, h);
        chk("bulundu", bulundu, f);
        chk("done_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_yon", yon, y);
            chk("hold_ikinci", ikinci_yon, y2);
            chk("hold_hops", atlama_sayisi, h);
            chk("hold_found", bulundu, f);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
    endtask

    initial begin
        rst           = 1'b1;
        kaynak_dugumu = '0;
        hedef_dugumu  = '0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_yon", yon, 0);
        chk("rst_ikinci", ikinci_yon, 0);
        chk("rst_hops", atlama_sayisi, 0);
        chk("rst_found", bulundu, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // src == dst
        do_req(4'd0, 4'd0, 1, 2'd0, 2'd0, 2'd0, 1'b1, 0);
        // 1-hop, d=2, with 5 cycles of out_ready low
        do_req(4'd0, 4'd5, 4, 2'd2, 2'd0, 2'd1, 1'b1, 5);
        // 1-hop with wrap: next(3,3) = 18 mod 16 = 2
        do_req(4'd3, 4'd2, 5, 2'd3, 2'd0, 2'd1, 1'b1, 0);
`ifdef YON_BULUCU_IKI_ATLAMA_EN
        do_req(4'd1, 4'd4, 11, 2'd1, 2'd1, 2'd2, 1'b1, 0);
        do_req(4'd0, 4'd9, 16, 2'd2, 2'd2, 2'd2, 1'b1, 0);
        // next(2,0)=11, next(11,1)=0 -> idx 1
        do_req(4'd2, 4'd0, 7, 2'd0, 2'd1, 2'd2, 1'b1, 2);
`else
        do_req(4'd0, 4'd9, 5, 2'd0, 2'd0, 2'd0, 1'b0, 0);
        do_req(4'd2, 4'd0, 5, 2'd0, 2'd0, 2'd0, 1'b0, 2);
`endif

        // Reset in the middle of a search drops the request.
        @(negedge clk);
        kaynak_dugumu = 4'd0;
        hedef_dugumu  = 4'd9;
        in_valid      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef YON_BULUCU_IKI_ATLAMA_EN
        repeat (6) @(negedge clk);
`else
        repeat (1) @(negedge clk);
`endif
        chk("pre_rst_busy", out_valid, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_yon", yon, 0);
        chk("midrst_ikinci", ikinci_yon, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_stale_out_valid", out_valid, 0);
        end
        do_req(4'd0, 4'd3, 2, 2'd0, 2'd0, 2'd1, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/yon_bulucu.md
YON_BULUCU -- requirements
Module: yon_bulucu

Interface
REQ-001 SHALL have the following ports: clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have: rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have: kaynak_dugumu, input, 4, source node of the request.
REQ-004 SHALL have: hedef_dugumu, input, 4, destination node of the request.
REQ-005 SHALL have: in_valid, input, 1, request valid.
REQ-006 SHALL have: in_ready, output, 1, request accepted when in_valid and in_ready are both high.
REQ-007 SHALL have: out_valid, output, 1, result valid.
REQ-008 SHALL have: out_ready, input, 1, result consumed when out_valid and out_ready are both high.
REQ-009 SHALL have: yon, output, 2, first-hop direction.
REQ-010 SHALL have: ikinci_yon, output, 2, second-hop direction; 0 unless atlama_sayisi is 2.
REQ-011 SHALL have: atlama_sayisi, output, 2, hop count, 0 to 2.
REQ-012 SHALL have: bulundu, output, 1, route found.

Function
REQ-013 SHALL use the hop rule next(n,d) = (4*n[1:0] + 3 + d) mod 16, with d in 0..3.
REQ-014 SHALL implement states IDLE, SEARCH1, SEARCH2 and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL, on accept in cycle T, register both nodes and leave IDLE.
REQ-016 SHALL go to DONE when src==dst, with atlama_sayisi=0, bulundu=1 and out_valid high at T+1.
REQ-017 SHALL otherwise enter SEARCH1 with idx=0 and test candidate d=idx, one candidate per cycle, in order 0..3.
REQ-018 SHALL go to DONE on a SEARCH1 match, with yon=d, atlama_sayisi=1 and out_valid high at T+2+d.
REQ-019 SHALL go to SEARCH2 with idx=0 after a miss at SEARCH1 idx=3.
REQ-020 SHALL test, in SEARCH2, d1=idx[3:2] and d2=idx[1:0], one candidate per cycle, idx 0..15, against next(next(src,d1),d2).
REQ-021 SHALL go to DONE on a SEARCH2 match, with yon=d1, ikinci_yon=d2, atlama_sayisi=2 and out_valid high at T+6+idx.
REQ-022 SHALL report the first match in search order; a shorter route always wins.
REQ-023 SHALL, after all candidates miss, go to DONE with bulundu=0 and yon, ikinci_yon and atlama_sayisi all 0.
REQ-024 SHALL hold outputs stable in DONE until out_ready is seen; the handshake cycle SHALL return to IDLE, and in_ready SHALL rise in the next cycle.
REQ-025 SHALL keep out_valid low in every state other than DONE.
REQ-026 SHALL ignore in_valid, kaynak_dugumu and hedef_dugumu outside IDLE.

Reset
REQ-027 SHALL, while rst is high, enter IDLE, with idx=0, out_valid=0, in_ready=0, and yon, ikinci_yon, atlama_sayisi and bulundu all 0.
REQ-028 SHALL raise in_ready in the first cycle after rst falls.
REQ-029 SHALL, when rst occurs mid-search or in DONE, drop the pending request with no result emitted.

Configuration
REQ-030 SHALL, with YON_BULUCU_IKI_ATLAMA_EN defined, include SEARCH2; full 2-hop coverage then always gives bulundu=1.
REQ-031 SHALL, without that macro, exclude SEARCH2 logic, go from a miss at SEARCH1 idx=3 to DONE with bulundu=0 (out_valid at T+5), and tie ikinci_yon to 0.

Structure
REQ-032 SHALL place the node width (4), the direction width (2), the state enumeration and the hop-rule constant (3) in a shared package.
REQ-033 SHALL implement the hop rule as combinational sub-module sonraki_dugum.
REQ-034 SHALL instantiate sonraki_dugum twice, chained for the 2-hop path; the second instance SHALL be omitted without the macro.

Verification
REQ-035 SHALL cover: src=0, dst=0, accept at T -> out_valid at T+1, bulundu=1, atlama_sayisi=0.
REQ-036 SHALL cover: src=0, dst=5 -> out_valid at T+4, yon=2, atlama_sayisi=1, bulundu=1.
REQ-037 SHALL cover, with macro: src=1, dst=4 -> out_valid at T+11, yon=1, ikinci_yon=1, atlama_sayisi=2.
REQ-038 SHALL cover: src=0, dst=9 -> with macro, out_valid at T+16, yon=2, ikinci_yon=2; without macro, out_valid at T+5, bulundu=0.
REQ-039 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0; after the handshake, in_ready=1 next cycle.
REQ-040 SHALL cover: rst pulsed during SEARCH2, then a new request src=0, dst=3 -> no stale result, out_valid at T'+2, yon=0.
